hzd_ctrl: RTL
=============

Name: hzd_ctrl

Overview:
Hazard/forwarding controller for the 5-stage core. It tracks the destination register of every in-flight instruction in EX, MEM and WB, and compares each decode-stage instruction's sources against them. It produces the registered forwarding selects consumed by the ALU-operand forwarding mux during EX, and the combinational load-use stall that freezes IF/ID and inserts a bubble. It also keeps a saturating stall-cycle performance counter.

Parameters:
REG_ADDR_W, 5, register-index width
CNT_W, 16, stall counter width

Ports:
i_clk  input  1  clock
i_rst_n  input  1  asynchronous active-low reset
i_id_valid  input  1  ID holds a valid instruction
i_id_rs1  input  REG_ADDR_W  ID source 1 index
i_id_rs2  input  REG_ADDR_W  ID source 2 index
i_id_rs1_used  input  1  instruction reads rs1 as an ALU operand (0 for auipc/lui)
i_id_rs2_used  input  1  instruction reads rs2 as an ALU operand (0 for imm/jal/jalr)
i_id_rd  input  REG_ADDR_W  ID destination index
i_id_reg_write  input  1  ID writes rd
i_id_mem_read  input  1  ID is a load
i_flush  input  1  taken branch/jump; discard ID instruction
i_hold  input  1  memory busy; freeze whole pipe
o_stall  output  1  hold PC and IF/ID, bubble into EX (combinational)
o_frwd_alu_op1  output  1  op1 from EX/MEM ALU result (distance 1)
o_frwd_mem_alu_op1  output  1  op1 from MEM/WB ALU result (distance 2)
o_frwd_mem_op1  output  1  op1 from MEM/WB load data (distance 2)
o_frwd_alu_op2  output  1  as above, op2
o_frwd_mem_alu_op2  output  1
o_frwd_mem_op2  output  1
o_stall_cnt  output  CNT_W  stall cycles, saturating

Behaviour:
- State: three slots S1 (EX), S2 (MEM), S3 (WB). Each slot holds {valid, rd, wen, load}. The six forwarding flags are registered. o_stall_cnt is registered.
- Reset (async, i_rst_n=0): all slot valid bits = 0, all o_frwd_* = 0, o_stall_cnt = 0. o_stall evaluates to 0 while the slots are empty. Reset mid-operation drops all in-flight tracking immediately.
- A slot match for source rsX requires all of: slot valid, slot wen, slot rd != 0, slot rd == rsX, and i_id_rsX_used. Register x0 never matches.
- Load-use: o_stall = i_id_valid & !i_flush & (rs1 or rs2 matches S1 & S1.load). This is purely combinational and independent of i_hold.
- Advance happens on each rising edge with i_hold = 0:
  - S3 <= S2, S2 <= S1.
  - S1 <= the ID instruction if i_id_valid & !i_flush & !o_stall. Otherwise S1 <= bubble (valid = 0).
  - Forwarding flags are computed for the instruction entering S1, against the pre-edge S1 (distance 1) and S2 (distance 2).
  - For each operand X:
    - frwd_alu_opX = match(S1) & !S1.load.
    - frwd_mem_alu_opX = !match(S1) & match(S2) & !S2.load.
    - frwd_mem_opX = !match(S1) & match(S2) & S2.load.
  - Distance 1 always has priority over distance 2.
  - A bubble entering S1 clears all six flags. At most one flag per operand is ever high.
- Latency: flags are valid in the cycle the consumer is in EX, i.e. one cycle after it was in ID.
- After a load-use stall, the load moves to S2 and the held consumer re-evaluates. The result is frwd_mem_opX = 1, with no second stall.
- i_hold = 1: slots, flags and the counter all hold their values. o_stall still reflects the combinational compare.
- i_flush together with a load-use match: flush wins, o_stall = 0, and a bubble enters S1.
- The rs1 and rs2 compares are independent: both operands may forward from different slots in the same cycle.
- o_stall_cnt increments on each advancing edge where o_stall = 1, and saturates at all-ones (no wrap).
- S3 is tracked only for completeness (register-file write-through is handled elsewhere). S3 produces no forwarding.

Test Plan:
1. ALU chain: add x5 followed by sub using x5 as rs1 → o_frwd_alu_op1 = 1 in sub's EX cycle, o_stall never asserted.
2. Distance 2: add x7, nop, then or with rs2 = x7 → o_frwd_mem_alu_op2 = 1, all other flags = 0.
3. Load-use: lw x3 followed by add with rs1 = x3 → o_stall = 1 for exactly one cycle, bubble in EX, then o_frwd_mem_op1 = 1 and o_stall_cnt = 1.
4. Priority and x0: add x4, add x4, then use x4 → only o_frwd_alu = 1. An instruction writing x0 followed by a reader of x0 → no forwarding.
5. Flush and hold:
   - Load-use match with i_flush = 1 → o_stall = 0 and the EX slot becomes a bubble.
   - i_hold high for 3 cycles → flags and counter unchanged.
6. Reset: assert i_rst_n = 0 mid-stream with flags set → all outputs 0 immediately. Counter preloaded near saturation → pins at 2^CNT_W − 1.

Source files
------------

// File: rtl/hzd_ctrl.sv
// Hazard/forwarding controller: tracks EX/MEM/WB destinations, raises the load-use
// stall and produces registered ALU-operand forwarding selects for the EX stage.
module hzd_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_id_valid,
  input  logic [REG_ADDR_W-1:0] i_id_rs1,
  input  logic [REG_ADDR_W-1:0] i_id_rs2,
  input  logic                  i_id_rs1_used,
  input  logic                  i_id_rs2_used,
  input  logic [REG_ADDR_W-1:0] i_id_rd,
  input  logic                  i_id_reg_write,
  input  logic                  i_id_mem_read,
  input  logic                  i_flush,
  input  logic                  i_hold,
  output logic                  o_stall,
  output logic                  o_frwd_alu_op1,
  output logic                  o_frwd_mem_alu_op1,
  output logic                  o_frwd_mem_op1,
  output logic                  o_frwd_alu_op2,
  output logic                  o_frwd_mem_alu_op2,
  output logic                  o_frwd_mem_op2,
  output logic [CNT_W-1:0]      o_stall_cnt
);

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  wen;
    logic                  load;
  } slot_t;

  slot_t s1_q, s2_q, s3_q;
  slot_t s1_d;
  logic [5:0] frwd_q, frwd_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic rs1_m1, rs1_m2, rs2_m1, rs2_m2;
  logic issue;

  // x0 is hardwired to zero, so a producer targeting it never matches.
  function automatic logic slotMatch(input slot_t s, input logic [REG_ADDR_W-1:0] rs,
                                     input logic used);
    return s.valid & s.wen & (s.rd != '0) & (s.rd == rs) & used;
  endfunction

  always_comb begin
    rs1_m1 = slotMatch(s1_q, i_id_rs1, i_id_rs1_used);
    rs1_m2 = slotMatch(s2_q, i_id_rs1, i_id_rs1_used);
    rs2_m1 = slotMatch(s1_q, i_id_rs2, i_id_rs2_used);
    rs2_m2 = slotMatch(s2_q, i_id_rs2, i_id_rs2_used);

    o_stall = i_id_valid & ~i_flush & (rs1_m1 | rs2_m1) & s1_q.load;
    issue   = i_id_valid & ~i_flush & ~o_stall;

    s1_d = '0;
    frwd_d = '0;
    if (issue) begin
      s1_d.valid = 1'b1;
      s1_d.rd    = i_id_rd;
      s1_d.wen   = i_id_reg_write;
      s1_d.load  = i_id_mem_read;
      frwd_d[5] = rs1_m1 & ~s1_q.load;
      frwd_d[4] = ~rs1_m1 & rs1_m2 & ~s2_q.load;
      frwd_d[3] = ~rs1_m1 & rs1_m2 & s2_q.load;
      frwd_d[2] = rs2_m1 & ~s1_q.load;
      frwd_d[1] = ~rs2_m1 & rs2_m2 & ~s2_q.load;
      frwd_d[0] = ~rs2_m1 & rs2_m2 & s2_q.load;
    end

    stall_cnt_d = stall_cnt_q;
    if (o_stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Every slot, flag and the counter freeze together while memory holds the pipe.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_q        <= '0;
      s2_q        <= '0;
      s3_q        <= '0;
      frwd_q      <= '0;
      stall_cnt_q <= '0;
    end else if (!i_hold) begin
      s3_q        <= s2_q;
      s2_q        <= s1_q;
      s1_q        <= s1_d;
      frwd_q      <= frwd_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign o_frwd_alu_op1     = frwd_q[5];
  assign o_frwd_mem_alu_op1 = frwd_q[4];
  assign o_frwd_mem_op1     = frwd_q[3];
  assign o_frwd_alu_op2     = frwd_q[2];
  assign o_frwd_mem_alu_op2 = frwd_q[1];
  assign o_frwd_mem_op2     = frwd_q[0];
  assign o_stall_cnt        = stall_cnt_q;

endmodule
